// File: rtl/cipher_csr_pkg.sv
// Shared types, bit positions and address-map helpers for the cipher CSR block.
package cipher_csr_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_TIMEOUT = 2;
  localparam int STATUS_OVERRUN = 3;

  function automatic int key_base();
    return 0;
  endfunction

  function automatic int msg_base(input int k);
    return k;
  endfunction

  function automatic int result_base(input int k, input int m);
    return k + m;
  endfunction

  // CTRL and STATUS always occupy the two highest word addresses.
  function automatic int ctrl_base(input int aw);
    return (1 << aw) - 2;
  endfunction

  function automatic int status_base(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/csr_be_reg.sv
// One data word with per-byte write enables and a synchronous clear.
module csr_be_reg #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_cipher_csr.sv
// Avalon-MM register file that loads key/message words, launches a start/done
// cipher core, captures its result and reports sticky status with an IRQ.
module avalon_cipher_csr
  import cipher_csr_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int KEY_WORDS   = 4,
  parameter int MSG_WORDS   = 4,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           AVL_READ,
  input  logic                           AVL_WRITE,
  input  logic                           AVL_CS,
  input  logic [DATA_W/8-1:0]            AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]              AVL_ADDR,
  input  logic [DATA_W-1:0]              AVL_WRITEDATA,
  output logic [DATA_W-1:0]              AVL_READDATA,
  output logic                           IRQ,
  output logic                           CORE_START,
  output logic [KEY_WORDS*DATA_W-1:0]    CORE_KEY,
  output logic [MSG_WORDS*DATA_W-1:0]    CORE_MSG,
  input  logic                           CORE_DONE,
  input  logic [MSG_WORDS*DATA_W-1:0]    CORE_RESULT,
  output logic [DATA_W-1:0]              EXPORT_DATA
);

  localparam int OPS      = KEY_WORDS + MSG_WORDS;
  localparam int RES_BASE = result_base(KEY_WORDS, MSG_WORDS);
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_base(ADDR_W));
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_base(ADDR_W));
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t            state_reg;
  logic              core_start_reg;
  logic              irq_en_reg;
  logic              done_reg;
  logic              timeout_reg;
  logic              overrun_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] op_reg     [OPS];
  logic [DATA_W-1:0] result_reg [MSG_WORDS];

  logic wr, rd, run, ctrl_wr, status_w1c, clear, start_acc;
  logic done_set, timeout_hit, timeout_set, overrun_set;

  assign wr         = AVL_CS & AVL_WRITE;
  assign rd         = AVL_CS & AVL_READ;
  assign run        = (state_reg == RUN);
  assign ctrl_wr    = wr & (AVL_ADDR == CTRL_ADDR) & AVL_BYTE_EN[0];
  assign status_w1c = wr & (AVL_ADDR == STATUS_ADDR) & AVL_BYTE_EN[0];
  // CLEAR takes priority over START within a single CTRL write.
  assign clear      = ctrl_wr & AVL_WRITEDATA[CTRL_CLEAR] & ~run;
  assign start_acc  = ctrl_wr & AVL_WRITEDATA[CTRL_START] & ~AVL_WRITEDATA[CTRL_CLEAR] & ~run;
  assign overrun_set = ctrl_wr & AVL_WRITEDATA[CTRL_START] & run;
  assign done_set    = run & CORE_DONE;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST);
  assign timeout_set = run & ~CORE_DONE & timeout_hit;

  // Key words followed by message words form one contiguous operand block.
  for (genvar gi = 0; gi < OPS; gi++) begin : g_op
    csr_be_reg #(.DATA_W(DATA_W)) u_reg (
      .clk   (CLK),
      .rst_n (RESET_N),
      .clr   (clear),
      .we    (wr & ~run & (AVL_ADDR == ADDR_W'(key_base() + gi))),
      .be    (AVL_BYTE_EN),
      .wdata (AVL_WRITEDATA),
      .q     (op_reg[gi])
    );
  end

  for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key
    assign CORE_KEY[(KEY_WORDS-1-gi)*DATA_W +: DATA_W] = op_reg[gi];
  end

  for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_msg
    assign CORE_MSG[(MSG_WORDS-1-gi)*DATA_W +: DATA_W] = op_reg[msg_base(KEY_WORDS) + gi];

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        result_reg[gi] <= '0;
      end else if (done_set) begin
        result_reg[gi] <= CORE_RESULT[(MSG_WORDS-1-gi)*DATA_W +: DATA_W];
      end else if (clear) begin
        result_reg[gi] <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      core_start_reg <= 1'b0;
      irq_en_reg     <= 1'b0;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      core_start_reg <= 1'b0;
      if (ctrl_wr) irq_en_reg <= AVL_WRITEDATA[CTRL_IRQ_EN];
      case (state_reg)
        IDLE: begin
          if (start_acc) begin
            state_reg      <= RUN;
            core_start_reg <= 1'b1;
            cnt_reg        <= '0;
          end
        end
        RUN: begin
          if (CORE_DONE || timeout_hit) state_reg <= IDLE;
          else                          cnt_reg   <= cnt_reg + CNT_W'(1);
        end
        default: state_reg <= IDLE;
      endcase
      // A hardware set in the same cycle as a W1C leaves the flag set.
      done_reg    <= done_set    | (done_reg    & ~(status_w1c & AVL_WRITEDATA[STATUS_DONE]));
      timeout_reg <= timeout_set | (timeout_reg & ~(status_w1c & AVL_WRITEDATA[STATUS_TIMEOUT]));
      overrun_reg <= overrun_set | (overrun_reg & ~(status_w1c & AVL_WRITEDATA[STATUS_OVERRUN]));
    end
  end

  always_comb begin
    AVL_READDATA = '0;
    if (rd) begin
      for (int i = 0; i < OPS; i++) begin
        if (AVL_ADDR == ADDR_W'(i)) AVL_READDATA = op_reg[i];
      end
      for (int i = 0; i < MSG_WORDS; i++) begin
        if (AVL_ADDR == ADDR_W'(RES_BASE + i)) AVL_READDATA = result_reg[i];
      end
      if (AVL_ADDR == CTRL_ADDR) AVL_READDATA[CTRL_IRQ_EN] = irq_en_reg;
      if (AVL_ADDR == STATUS_ADDR) begin
        AVL_READDATA[STATUS_BUSY]    = run;
        AVL_READDATA[STATUS_DONE]    = done_reg;
        AVL_READDATA[STATUS_TIMEOUT] = timeout_reg;
        AVL_READDATA[STATUS_OVERRUN] = overrun_reg;
      end
    end
  end

  assign IRQ         = irq_en_reg & (done_reg | timeout_reg);
  assign CORE_START  = core_start_reg;
  assign EXPORT_DATA = op_reg[0];

endmodule
